// File: rtl/indicator_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : indicator_ctrl                                                |
// | Purpose  : Button/USB/charger-STAT driven red/green indicator controller |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module indicator_ctrl #(
    parameter int DEB_CYC    = 16,
    parameter int STAT_WIN   = 64,
    parameter int SHOW_CYC   = 500,
    parameter int BLINK_HALF = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    input  logic usb,
    input  logic stat,
    input  logic level,
    output logic red,
    output logic green,
    output logic charging,
    output logic fault
);

    localparam int c_deb_w   = (DEB_CYC    > 1) ? $clog2(DEB_CYC)    : 1;
    localparam int c_win_w   = (STAT_WIN   > 1) ? $clog2(STAT_WIN)   : 1;
    localparam int c_show_w  = (SHOW_CYC   > 1) ? $clog2(SHOW_CYC)   : 1;
    localparam int c_blink_w = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [c_deb_w-1:0]   c_deb_last   = c_deb_w'(DEB_CYC - 1);
    localparam logic [c_win_w-1:0]   c_win_last   = c_win_w'(STAT_WIN - 1);
    localparam logic [c_show_w-1:0]  c_show_last  = c_show_w'(SHOW_CYC - 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_SHOW  = 2'd1,
        ST_USB   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CL_IDLE = 2'd0,
        CL_CHG  = 2'd1,
        CL_FLT  = 2'd2
    } chg_class_t;

    logic                 r_b_meta, r_b_s, r_u_meta, r_u_s, r_s_meta, r_s_s, r_s_q;
    logic                 r_b_db, r_b_db_q;
    logic [c_deb_w-1:0]   r_deb_cnt;
    logic [c_win_w-1:0]   r_win_cnt;
    logic [1:0]           r_edge_cnt;
    chg_class_t           r_chg_class;
    state_t               r_state, w_state_nxt;
    logic [c_show_w-1:0]  r_timer;
    logic                 r_blink;
    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_red, r_green, r_charging, r_fault;
    logic                 w_red_nxt, w_green_nxt;
    logic                 w_press, w_s_edge, w_timer_run;
    logic [1:0]           w_edge_sum;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_b_meta <= 1'b0;
            r_b_s    <= 1'b0;
            r_u_meta <= 1'b0;
            r_u_s    <= 1'b0;
            r_s_meta <= 1'b0;
            r_s_s    <= 1'b0;
            r_s_q    <= 1'b0;
        end else begin
            r_b_meta <= button;
            r_b_s    <= r_b_meta;
            r_u_meta <= usb;
            r_u_s    <= r_u_meta;
            r_s_meta <= stat;
            r_s_s    <= r_s_meta;
            r_s_q    <= r_s_s;
        end
    end

    // Any cycle agreeing with the accepted level restarts qualification.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_b_db    <= 1'b0;
            r_b_db_q  <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_b_db_q <= r_b_db;
            if (r_b_s == r_b_db) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == c_deb_last) begin
                r_b_db    <= r_b_s;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

    assign w_press    = r_b_db & ~r_b_db_q;
    assign w_s_edge   = r_s_s ^ r_s_q;
    // Edge seen on the last window cycle still counts toward that window.
    assign w_edge_sum = (r_edge_cnt == 2'd2) ? 2'd2 : r_edge_cnt + {1'b0, w_s_edge};

    always_ff @(posedge clk) begin
        if (!rst || !r_u_s) begin
            r_win_cnt   <= '0;
            r_edge_cnt  <= 2'd0;
            r_chg_class <= CL_IDLE;
        end else if (r_win_cnt == c_win_last) begin
            r_win_cnt  <= '0;
            r_edge_cnt <= 2'd0;
            if (w_edge_sum == 2'd2) begin
                r_chg_class <= CL_FLT;
            end else if (w_edge_sum == 2'd0) begin
                r_chg_class <= r_s_s ? CL_IDLE : CL_CHG;
            end
        end else begin
            r_win_cnt  <= r_win_cnt + 1'b1;
            r_edge_cnt <= w_edge_sum;
        end
    end

    assign w_timer_run = (r_state == ST_SHOW) && (r_timer != '0);

    always_comb begin
        w_state_nxt = ST_OFF;
        if (r_u_s && (r_chg_class == CL_FLT)) begin
            w_state_nxt = ST_FAULT;
        end else if (r_u_s) begin
            w_state_nxt = ST_USB;
        end else if ((w_press && ((r_state == ST_OFF) || (r_state == ST_SHOW))) || w_timer_run) begin
            w_state_nxt = ST_SHOW;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_OFF;
            r_timer     <= '0;
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == ST_SHOW) begin
                r_timer <= ((r_state != ST_SHOW) || w_press) ? c_show_last : r_timer - 1'b1;
            end else begin
                r_timer <= '0;
            end
            if (w_state_nxt != ST_FAULT) begin
                r_blink     <= 1'b0;
                r_blink_cnt <= '0;
            end else if (r_state != ST_FAULT) begin
                r_blink     <= 1'b1;
                r_blink_cnt <= '0;
            end else if (r_blink_cnt == c_blink_last) begin
                r_blink     <= ~r_blink;
                r_blink_cnt <= '0;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_red_nxt   = 1'b0;
        w_green_nxt = 1'b0;
        case (r_state)
            ST_SHOW: begin
                w_green_nxt = 1'b1;
                w_red_nxt   = ~level;
            end
            ST_USB: begin
                w_green_nxt = 1'b1;
                w_red_nxt   = (r_chg_class == CL_CHG) | ~level;
            end
            ST_FAULT: w_red_nxt = r_blink;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_red      <= 1'b0;
            r_green    <= 1'b0;
            r_charging <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_red      <= w_red_nxt;
            r_green    <= w_green_nxt;
            r_charging <= (r_chg_class == CL_CHG);
            r_fault    <= (r_chg_class == CL_FLT);
        end
    end

    assign red      = r_red;
    assign green    = r_green;
    assign charging = r_charging;
    assign fault    = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_indicator_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_indicator_ctrl                                             |
// | Purpose  : Randomized, model-checked bench for indicator_ctrl            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_indicator_ctrl;

    localparam int DEB_CYC    = 16;
    localparam int STAT_WIN   = 64;
    localparam int SHOW_CYC   = 500;
    localparam int BLINK_HALF = 8;

    localparam int c_off = 0, c_show = 1, c_usb = 2, c_fault = 3;
    localparam int c_idle = 0, c_chg = 1, c_flt = 2;

    logic clk = 1'b0, rst = 1'b0;
    logic button = 1'b0, usb = 1'b0, stat = 1'b0, level = 1'b0;
    logic red, green, charging, fault;

    int checks = 0;
    int errors = 0;

    // Reference model: cycle index plus integer deadlines instead of counters.
    int cyc = 0;
    bit m_b1, m_bs, m_u1, m_us, m_s1, m_ss, m_sprev, m_db, m_dbq;
    int m_run, m_st, m_cls, m_wpos, m_edges, m_deadline, m_fstart;
    bit m_red, m_green, m_chg, m_flt;
    int tog_per = 0, tog_cnt = 0;

    indicator_ctrl #(
        .DEB_CYC   (DEB_CYC),
        .STAT_WIN  (STAT_WIN),
        .SHOW_CYC  (SHOW_CYC),
        .BLINK_HALF(BLINK_HALF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .button  (button),
        .usb     (usb),
        .stat    (stat),
        .level   (level),
        .red     (red),
        .green   (green),
        .charging(charging),
        .fault   (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_step();
        bit press, running, blink;
        int nst, e;
        if (!rst) begin
            {m_b1, m_bs, m_u1, m_us, m_s1, m_ss, m_sprev, m_db, m_dbq} = '0;
            {m_red, m_green, m_chg, m_flt} = '0;
            m_run = 0; m_st = c_off; m_cls = c_idle; m_wpos = 0; m_edges = 0;
        end else begin
            blink = (m_st == c_fault) && ((((cyc - m_fstart) / BLINK_HALF) % 2) == 0);
            case (m_st)
                c_show:  begin m_green = 1; m_red = !level; end
                c_usb:   begin m_green = 1; m_red = (m_cls == c_chg) || !level; end
                c_fault: begin m_green = 0; m_red = blink; end
                default: begin m_green = 0; m_red = 0; end
            endcase
            m_chg = (m_cls == c_chg);
            m_flt = (m_cls == c_flt);

            press   = m_db && !m_dbq;
            running = (m_st == c_show) && (cyc < m_deadline);
            if (m_us && m_cls == c_flt)                                  nst = c_fault;
            else if (m_us)                                               nst = c_usb;
            else if ((press && (m_st == c_off || m_st == c_show)) || running) nst = c_show;
            else                                                         nst = c_off;
            if (nst == c_show && (m_st != c_show || press)) m_deadline = cyc + SHOW_CYC;
            if (nst == c_fault && m_st != c_fault)          m_fstart = cyc + 1;
            m_st = nst;

            if (!m_us) begin
                m_cls = c_idle; m_wpos = 0; m_edges = 0;
            end else begin
                e = m_edges + ((m_ss != m_sprev) ? 1 : 0);
                if (m_wpos == STAT_WIN - 1) begin
                    if (e >= 2)      m_cls = c_flt;
                    else if (e == 0) m_cls = m_ss ? c_idle : c_chg;
                    m_edges = 0; m_wpos = 0;
                end else begin
                    m_edges = e; m_wpos++;
                end
            end

            m_dbq = m_db;
            if (m_bs == m_db) m_run = 0;
            else begin
                m_run++;
                if (m_run == DEB_CYC) begin m_db = m_bs; m_run = 0; end
            end

            m_sprev = m_ss;
            m_bs = m_b1; m_b1 = button;
            m_us = m_u1; m_u1 = usb;
            m_ss = m_s1; m_s1 = stat;
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("red", red, m_red);
        check("green", green, m_green);
        check("charging", charging, m_chg);
        check("fault", fault, m_flt);
        if (tog_per != 0) begin
            tog_cnt++;
            if (tog_cnt >= tog_per) begin stat = ~stat; tog_cnt = 0; end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_btn();
        button = 1'b1;
        run(DEB_CYC + 6);
        button = 1'b0;
    endtask

    initial begin
        int cnt_g, cnt_r, k, tog, found, btn_left, mode;
        bit prev_r;

        run(3);
        check("reset_red", red, 1'b0);
        check("reset_green", green, 1'b0);
        check("reset_charging", charging, 1'b0);
        check("reset_fault", fault, 1'b0);
        rst = 1'b1;
        run(5);

        // Long press: display for exactly SHOW_CYC cycles.
        cnt_g = 0; cnt_r = 0;
        button = 1'b1;
        for (int i = 0; i < DEB_CYC + 10; i++) begin tick(); cnt_g += green; cnt_r += red; end
        button = 1'b0;
        for (int i = 0; i < SHOW_CYC + 60; i++) begin tick(); cnt_g += green; cnt_r += red; end
        check("show_len_green", cnt_g, SHOW_CYC);
        check("show_len_red", cnt_r, SHOW_CYC);

        // Bouncing button never qualifies.
        cnt_g = 0;
        for (int i = 0; i < 200; ) begin
            int hi, lo;
            hi = $urandom_range(DEB_CYC - 2, 1);
            lo = $urandom_range(6, 1);
            button = 1'b1;
            for (int j = 0; j < hi; j++) begin tick(); cnt_g += green + red; end
            button = 1'b0;
            for (int j = 0; j < lo; j++) begin tick(); cnt_g += green + red; end
            i += hi + lo;
        end
        check("bounce_dark", cnt_g, 0);
        run(DEB_CYC + 4);

        // Retrigger near timer end, then reset mid-SHOW.
        button = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin tick(); found = green; end
        check("show_start", found, 1);
        k = 1;
        while (k < DEB_CYC + 6) begin tick(); k++; end
        button = 1'b0;
        while (k < SHOW_CYC - 10 - (DEB_CYC + 3)) begin tick(); k++; end
        press_btn();
        k += DEB_CYC + 6;
        while (k < SHOW_CYC + 5) begin tick(); k++; end
        check("retrig_ext_green", green, 1'b1);
        run(40);
        rst = 1'b0;
        tick();
        check("rst_mid_red", red, 1'b0);
        check("rst_mid_green", green, 1'b0);
        rst = 1'b1;
        run(10);
        check("rst_release_green", green, 1'b0);

        // USB plugged, charging.
        usb = 1'b1; stat = 1'b0; level = 1'b0;
        run(2 * STAT_WIN + 4);
        check("usb_chg_charging", charging, 1'b1);
        check("usb_chg_green", green, 1'b1);
        check("usb_chg_red", red, 1'b1);

        // USB plugged, idle and full; button ignored.
        usb = 1'b0; run(6);
        stat = 1'b1; level = 1'b1; run(6);
        usb = 1'b1;
        run(3 * STAT_WIN);
        check("usb_idle_charging", charging, 1'b0);
        check("usb_idle_fault", fault, 1'b0);
        check("usb_idle_green", green, 1'b1);
        check("usb_idle_red", red, 1'b0);
        press_btn();
        run(60);
        check("usb_press_green", green, 1'b1);
        check("usb_press_red", red, 1'b0);

        // Toggling STAT: fault with blinking red.
        tog_per = 5; tog_cnt = 0;
        found = 0;
        for (int i = 0; i < 3 * STAT_WIN && !found; i++) begin tick(); found = !green; end
        check("fault_entry", found, 1);
        check("blink_start", red, 1'b1);
        prev_r = red; tog = 0;
        for (int i = 0; i < 64; i++) begin tick(); tog += (red != prev_r); prev_r = red; end
        check("blink_toggles", tog, 64 / BLINK_HALF);
        check("fault_flag", fault, 1'b1);
        usb = 1'b0;
        run(6);
        check("unplug_fault", fault, 1'b0);
        check("unplug_red", red, 1'b0);
        check("unplug_green", green, 1'b0);
        tog_per = 0;

        // Randomized mix against the model.
        btn_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(199) == 0) usb = ~usb;
            if ($urandom_range(149) == 0) begin
                mode = $urandom_range(2);
                tog_per = (mode == 2) ? $urandom_range(10, 2) : 0;
                if (mode < 2) stat = mode[0];
            end
            if (btn_left == 0) begin
                button = 1'b0;
                if ($urandom_range(99) == 0) begin button = 1'b1; btn_left = $urandom_range(40, 1); end
            end else btn_left--;
            if ($urandom_range(299) == 0) level = ~level;
            rst = ($urandom_range(1499) == 0) ? 1'b0 : 1'b1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/indicator_ctrl.md
INDICATOR_CTRL -- requirements
Module: indicator_ctrl

Interface
REQ-001 Parameter DEB_CYC, default 16: consecutive stable cycles required to accept a new button level.
REQ-002 Parameter STAT_WIN, default 64: length of the charger-STAT edge-count window, in cycles.
REQ-003 Parameter SHOW_CYC, default 500: duration of the button-triggered display, in cycles.
REQ-004 Parameter BLINK_HALF, default 8: red half-period in FAULT, in cycles.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 button  input  1  raw push button; 1 = pressed; asynchronous to clk.
REQ-008 usb  input  1  1 = USB supply plugged in; asynchronous.
REQ-009 stat  input  1  charger STAT pin; low = charging, high = not charging, toggling = fault; asynchronous.
REQ-010 level  input  1  1 = battery full; quasi-static, sampled directly.
REQ-011 red  output  1  red LED drive; registered.
REQ-012 green  output  1  green LED drive; registered.
REQ-013 charging  output  1  1 when the decoded charger class is CHG; registered.
REQ-014 fault  output  1  1 when the decoded charger class is FLT; registered.

Function
REQ-015 button, usb and stat SHALL each pass through a 2-flop synchronizer before use; the internal signals are b_s, u_s and s_s.
REQ-016 Debounce: b_db SHALL take the value of b_s after b_s has differed from b_db for DEB_CYC consecutive cycles; any cycle with b_s == b_db SHALL clear the count.
REQ-017 A press event SHALL be a single-cycle pulse on the 0->1 transition of b_db.
REQ-018 STAT decoder: while u_s=1, a window counter SHALL count 0..STAT_WIN-1 and wrap; an edge counter SHALL count s_s transitions and saturate at 2.
REQ-019 At the last cycle of each window, the charger class SHALL update as follows:
- edges >= 2 -> FLT
- edges == 0 and s_s = 0 -> CHG
- edges == 0 and s_s = 1 -> IDLE
- edges == 1 -> class unchanged
The edge counter SHALL then clear.
REQ-020 While u_s=0, the class SHALL be forced to IDLE and both window counters SHALL be held at 0.
REQ-021 Display FSM states are OFF, SHOW, USB and FAULT; transitions are evaluated every cycle in this priority order:
- u_s=1 and class FLT -> FAULT
- u_s=1 -> USB
- press event, or SHOW with the timer still running -> SHOW
- else -> OFF
REQ-022 The SHOW timer SHALL load SHOW_CYC-1 on entry to SHOW and on every press event while in SHOW (retrigger), and SHALL decrement each cycle; SHOW SHALL exit to OFF on the cycle after the timer reaches 0.
REQ-023 A press event SHALL be ignored in USB and FAULT; leaving USB/FAULT because u_s falls SHALL go to OFF, not SHOW.
REQ-024 LED outputs SHALL be registered from the current state, so they lag the state by 1 cycle:
- OFF: red=0, green=0
- SHOW: green=1, red=~level
- USB: green=1, red=(class==CHG) | ~level
- FAULT: green=0, red=blink
REQ-025 The blink signal SHALL load 1 and restart its BLINK_HALF counter on entry to FAULT, and SHALL toggle every BLINK_HALF cycles while in FAULT.
REQ-026 The charging and fault outputs SHALL be the registered class decode, independent of FSM state.
REQ-027 All counters SHALL be sized to $clog2 of their parameter (minimum 1 bit) and SHALL never wrap other than as specified.

Reset
REQ-028 While rst=0 at a clock edge, the following SHALL be set:
- FSM state -> OFF
- class -> IDLE
- b_db -> 0
- synchronizers, counters and blink -> 0
- red, green, charging, fault -> 0
REQ-029 Reset asserted mid-operation (any state) SHALL take effect at the next edge; after release, the FSM SHALL re-qualify from OFF, and class SHALL re-qualify only after a full STAT window.

Verification
REQ-030 usb=0, level=0, button held 1 for DEB_CYC+10 cycles -> press accepted; green=1 and red=1 for SHOW_CYC cycles, then both 0.
REQ-031 usb=0, button bouncing with high periods shorter than DEB_CYC for 200 cycles -> red=0 and green=0 throughout.
REQ-032 usb=1, stat=0 steady, level=0 -> within 2 windows plus 4 cycles: charging=1, green=1, red=1.
REQ-033 usb=1, stat=1 steady, level=1 -> charging=0, fault=0, green=1, red=0; pressing the button causes no change.
REQ-034 usb=1, stat toggling every 5 cycles -> fault=1, green=0, red toggles with BLINK_HALF=8 half-period, starting at 1; dropping usb -> OFF and fault=0.
REQ-035 Press during SHOW at timer=10 -> display extended to SHOW_CYC cycles from the new press; rst=0 mid-SHOW -> all outputs 0 on the next edge.
